risc16f_io_bus: RTL

Memory-mapped I/O slave on the risc16f data port, directly downstream of the core's daddr/ddout/doe/dwe outputs. Decodes the window 0x0200-0x020F and provides:
- LED registers (24-bit led output)
- a UART transmitter fed by a small TX FIFO
- a 32-bit free-running cycle timer

The top level muxes io_dout onto ddin when io_sel=1 and blocks memory writes for those cycles; all other addresses go to data memory.

---
 rtl/risc16f_io_bus.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/risc16f_io_bus.sv
// Memory-mapped I/O slave for the risc16f data port: LED registers, a FIFO-fed UART
// transmitter and a 32-bit free-running cycle timer in the window 0x0200-0x020F.
module risc16f_io_bus #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] daddr,
  input  logic [15:0] ddout,
  input  logic        doe,
  input  logic        dwe,
  output logic        io_sel,
  output logic [15:0] io_dout,
  output logic [23:0] led,
  output logic        uart_tx
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam logic [BaudW-1:0] BaudMax  = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [PtrW:0]    FifoFull = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Byte offset bit 0 plays no part in the decode.
  logic unused_addr_bit;
  assign unused_addr_bit = daddr[0];

  logic [2:0] offset;
  logic       wr_en;
  logic       wr_led01, wr_led2, wr_uart, wr_clr, wr_tmr, snap_en;

  assign io_sel   = (daddr[15:4] == 12'h020);
  assign offset   = daddr[3:1];
  assign wr_en    = dwe && io_sel;
  assign wr_led01 = wr_en && (offset == 3'd0);
  assign wr_led2  = wr_en && (offset == 3'd1);
  assign wr_uart  = wr_en && (offset == 3'd2);
  assign wr_clr   = wr_en && (offset == 3'd3);
  assign wr_tmr   = wr_en && (offset == 3'd4);
  assign snap_en  = doe && io_sel && (offset == 3'd4);

  // LED registers
  logic [7:0] led0_q, led1_q, led2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led0_q <= 8'h00;
      led1_q <= 8'h00;
      led2_q <= 8'h00;
    end else begin
      if (wr_led01) begin
        led0_q <= ddout[7:0];
        led1_q <= ddout[15:8];
      end
      if (wr_led2) begin
        led2_q <= ddout[7:0];
      end
    end
  end

  assign led = {led2_q, led1_q, led0_q};

  // Timer and high-half snapshot
  logic [31:0] tmr_q, tmr_d;
  logic [15:0] snap_q, snap_d;

  always_comb begin
    tmr_d  = wr_tmr ? 32'h0000_0000 : tmr_q + 32'h0000_0001;
    snap_d = snap_en ? tmr_q[31:16] : snap_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q  <= 32'h0000_0000;
      snap_q <= 16'h0000;
    end else begin
      tmr_q  <= tmr_d;
      snap_q <= snap_d;
    end
  end

  // TX FIFO: read pointer plus occupancy count
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_idx;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            fifo_full, fifo_empty, push_ok, pop;
  logic            ovf_q, ovf_d;

  assign fifo_full  = (cnt_q == FifoFull);
  assign fifo_empty = (cnt_q == '0);
  assign push_ok    = wr_uart && !fifo_full;
  assign wr_idx     = rd_ptr_q + cnt_q[PtrW-1:0];

  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // A dropped push sets ovf even when a clear lands on the same edge.
    if (wr_uart && fifo_full) begin
      ovf_d = 1'b1;
    end else if (wr_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_idx] <= ddout[7:0];
    end
  end

  // Serializer
  state_e         state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    uart_tx = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          baud_d  = BaudMax;
          state_d = StStart;
        end
      end
      StStart: begin
        uart_tx = 1'b0;
        if (baud_q == '0) begin
          baud_d  = BaudMax;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StData: begin
        uart_tx = shift_q[0];
        if (baud_q == '0) begin
          baud_d  = BaudMax;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StStop: begin
        if (baud_q == '0) begin
          state_d = StIdle;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read mux
  logic busy;
  assign busy = (state_q != StIdle) || !fifo_empty;

  always_comb begin
    io_dout = 16'h0000;
    if (io_sel) begin
      case (offset)
        3'd0:    io_dout = {led1_q, led0_q};
        3'd1:    io_dout = {8'h00, led2_q};
        3'd2:    io_dout = {13'b0, ovf_q, fifo_full, busy};
        3'd4:    io_dout = tmr_q[15:0];
        3'd5:    io_dout = snap_q;
        default: io_dout = 16'h0000;
      endcase
    end
  end

endmodule
